// File: rtl/mcu_spi_host_pkg.sv
// mcu_spi_host_pkg: FSM state encoding and MCU target codes shared by the SPI host.
package mcu_spi_host_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, NEXT, GAP} state_t;
    localparam logic [7:0] TGT_HID = 8'h01;
    localparam logic [7:0] TGT_OSD = 8'h02;
    localparam logic [7:0] TGT_SDC = 8'h03;
endpackage

// File: rtl/mcu_spi_host_if.sv
// mcu_spi_host_if: byte stream in/out, status and SPI pins of the host; master is the host side.
interface mcu_spi_host_if;
    logic in_valid, in_last, in_ready;
    logic [7:0] in_data;
    logic out_valid, out_start;
    logic [7:0] out_data;
    logic busy;
    logic spi_ss, spi_clk, spi_mosi, spi_miso;
    logic [15:0] frame_count;
    modport master (
        input in_valid, in_data, in_last, spi_miso,
        output in_ready, out_valid, out_data, out_start, busy, spi_ss, spi_clk, spi_mosi, frame_count
    );
    modport slave (
        output in_valid, in_data, in_last, spi_miso,
        input in_ready, out_valid, out_data, out_start, busy, spi_ss, spi_clk, spi_mosi, frame_count
    );
endinterface

// File: rtl/mcu_spi_host_sclk.sv
// mcu_spi_host_sclk: SCLK divider toggling every CLK_DIV cycles while run is high, with
// rise/fall pulses marking the cycle whose closing edge changes spi_clk.
module mcu_spi_host_sclk #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic spi_clk,
    output logic rise,
    output logic fall
);
    localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [W-1:0] cnt;
    logic wrap;
    assign wrap = run && cnt == W'(CLK_DIV - 1);
    assign rise = wrap && !spi_clk;
    assign fall = wrap && spi_clk;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            spi_clk <= 1'b0;
        end else if (!run) begin
            cnt     <= '0;
            spi_clk <= 1'b0;
        end else begin
            cnt     <= wrap ? '0 : cnt + 1'b1;
            spi_clk <= spi_clk ^ wrap;
        end
    end
endmodule

// File: rtl/mcu_spi_host.sv
// mcu_spi_host: mode-0 MSB-first SPI master for the MCU framed byte protocol.
// Define MCU_SPI_HOST_STATS_EN to keep a live completed-frame counter.
module mcu_spi_host
    import mcu_spi_host_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8
) (
    input logic clk,
    input logic reset,
    mcu_spi_host_if.master bus
);
    state_t state;
    logic [6:0] tx;
    logic [7:0] rx;
    logic [2:0] bit_cnt;
    logic last, first, rise, fall, run, done;
    logic [15:0] gap_cnt;
    assign run  = state == SETUP || state == SHIFT;
    assign done = state == SHIFT && fall && bit_cnt == 3'd7;
    mcu_spi_host_sclk #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk(clk), .reset(reset), .run(run), .spi_clk(bus.spi_clk), .rise(rise), .fall(fall)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_start <= 1'b0;
            bus.busy      <= 1'b0;
            bus.spi_ss    <= 1'b1;
            bus.spi_mosi  <= 1'b0;
            tx            <= '0;
            rx            <= '0;
            bit_cnt       <= '0;
            last          <= 1'b0;
            first         <= 1'b0;
            gap_cnt       <= '0;
        end else begin
            bus.out_valid <= 1'b0;
            if (rise) rx <= {rx[6:0], bus.spi_miso};
            case (state)
                IDLE, NEXT: begin
                    if (bus.in_valid && bus.in_ready) begin
                        state        <= SETUP;
                        bus.in_ready <= 1'b0;
                        bus.spi_ss   <= 1'b0;
                        bus.busy     <= 1'b1;
                        bus.spi_mosi <= bus.in_data[7];
                        tx           <= bus.in_data[6:0];
                        last         <= bus.in_last;
                        first        <= state == IDLE;
                    end else begin
                        bus.in_ready <= 1'b1;
                    end
                end
                SETUP: if (rise) state <= SHIFT;
                SHIFT: begin
                    if (fall) begin
                        bit_cnt      <= bit_cnt + 1'b1;
                        bus.spi_mosi <= done ? 1'b0 : tx[6];
                        tx           <= {tx[5:0], 1'b0};
                    end
                    if (done) begin
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= rx;
                        bus.out_start <= first;
                        state         <= last ? GAP : NEXT;
                        bus.spi_ss    <= last;
                        bus.in_ready  <= !last;
                        gap_cnt       <= '0;
                    end
                end
                GAP: begin
                    if (gap_cnt == 16'(CS_GAP - 1)) begin
                        state        <= IDLE;
                        bus.busy     <= 1'b0;
                        bus.in_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef MCU_SPI_HOST_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) bus.frame_count <= '0;
        else if (done && last) bus.frame_count <= bus.frame_count + 1'b1;
    end
`else
    assign bus.frame_count = 16'h0000;
`endif
endmodule
